// File: rtl/instr_mem_responder.sv
// Instruction-side memory: zero-latency dual-word fetch port plus a length-prefixed
// byte-stream program loader that holds the core (and serves NOPs) while writing.
module instr_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    output logic [31:0] current_word,
    output logic [31:0] next_word,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_overflow
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [23:0] r_shift;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_wr_ptr;
    logic [31:0] r_word_cnt;
    logic        r_load_ready;
    logic        r_cpu_hold;
    logic        r_load_done;
    logic        r_load_overflow;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_last_byte;
    logic [31:0]   w_word;
    logic          w_we;
    logic          w_loading;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_rd_idx_nxt;
    logic          w_unused;

    assign w_accept    = load_valid && r_load_ready;
    assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
    // The three earlier bytes sit in r_shift, so the completed word is available combinationally.
    assign w_word      = {load_byte, r_shift};
    assign w_we        = (r_state == S_DATA) && w_last_byte && (r_wr_ptr < DEPTH32);
    assign w_loading   = (r_state == S_LEN) || (r_state == S_DATA);

    assign w_rd_idx     = address[AW+1:2];
    assign w_rd_idx_nxt = w_rd_idx + AW'(1);
    assign w_unused     = ^{address[31:AW+2], address[1:0]};

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_word;
        end
    end

    always_comb begin
        current_word = r_mem[w_rd_idx];
        next_word    = r_mem[w_rd_idx_nxt];
        if (w_loading) begin
            current_word = NOP_WORD;
            next_word    = NOP_WORD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_shift         <= '0;
            r_byte_cnt      <= '0;
            r_wr_ptr        <= '0;
            r_word_cnt      <= '0;
            r_load_ready    <= 1'b0;
            r_cpu_hold      <= 1'b0;
            r_load_done     <= 1'b0;
            r_load_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift    <= {load_byte, r_shift[23:8]};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        r_state         <= S_LEN;
                        r_byte_cnt      <= '0;
                        r_wr_ptr        <= '0;
                        r_load_overflow <= 1'b0;
                        r_load_ready    <= 1'b1;
                        r_cpu_hold      <= 1'b1;
                        r_load_done     <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (w_last_byte) begin
                        r_word_cnt <= w_word;
                        if (w_word > DEPTH32) begin
                            r_load_overflow <= 1'b1;
                        end
                        if (w_word == '0) begin
                            r_state      <= S_DONE;
                            r_load_ready <= 1'b0;
                            r_cpu_hold   <= 1'b0;
                            r_load_done  <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_last_byte) begin
                        r_wr_ptr <= r_wr_ptr + 32'd1;
                        if ((r_wr_ptr + 32'd1) == r_word_cnt) begin
                            r_state      <= S_DONE;
                            r_load_ready <= 1'b0;
                            r_cpu_hold   <= 1'b0;
                            r_load_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign load_ready    = r_load_ready;
    assign cpu_hold      = r_cpu_hold;
    assign load_done     = r_load_done;
    assign load_overflow = r_load_overflow;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: table-driven read vectors, loader
// sequences, and random reads checked against a word-array model of the memory.
module tb_instr_mem_responder;

    localparam int          D   = 64;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] current_word;
    logic [31:0] next_word;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_ready;
    logic        cpu_hold;
    logic        load_done;
    logic        load_overflow;

    instr_mem_responder #(
        .DEPTH_WORDS(D),
        .NOP_WORD   (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .current_word (current_word),
        .next_word    (next_word),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_byte    (load_byte),
        .load_ready   (load_ready),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_overflow(load_overflow)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] mmem [D];
    logic [31:0] g_words[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] cur;
        logic [31:0] nxt;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [31:0] pat(input int unsigned i);
        return ((i + 1) * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input int n);
        for (int i = 0; i < n; i++) begin
            int unsigned idx;
            address = $urandom;
            #1;
            idx = int'(address[31:2]) % D;
            chk("rand_cur", current_word, mmem[idx]);
            chk("rand_next", next_word, mmem[(idx + 1) % D]);
        end
    endtask

    // Feeds header + g_words with random gaps; the model expects the first D words stored.
    task automatic run_load(input logic [31:0] hdr, input bit gaps);
        logic [7:0] bytes[$];
        int unsigned k;
        logic exp_ovf;
        exp_ovf = (hdr > 32'(D));
        for (int b = 0; b < 4; b++) bytes.push_back(hdr[8*b +: 8]);
        foreach (g_words[w]) begin
            logic [31:0] wd;
            wd = g_words[w];
            for (int b = 0; b < 4; b++) bytes.push_back(wd[8*b +: 8]);
        end
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("start_hold", cpu_hold, 1);
        chk("start_ready", load_ready, 1);
        chk("start_done", load_done, 0);
        chk("start_ovf", load_overflow, 0);
        k = 0;
        while (k < bytes.size()) begin
            bit acc;
            address = $urandom;
            acc = !(gaps && $urandom_range(3) == 0);
            if (acc) begin
                load_valid = 1'b1;
                load_byte  = bytes[k];
                k++;
            end else begin
                load_valid = 1'b0;
                load_byte  = 8'($urandom);
                load_start = ($urandom_range(7) == 0);
            end
            #1;
            chk("nop_cur", current_word, NOP);
            chk("nop_next", next_word, NOP);
            chk("hold", cpu_hold, 1);
            chk("ready", load_ready, 1);
            if (k == bytes.size() && acc) chk("done_early", load_done, 0);
            tick();
            load_valid = 1'b0;
            load_start = 1'b0;
            if (acc && k == 4) chk("ovf_hdr", load_overflow, exp_ovf);
        end
        chk("end_done", load_done, 1);
        chk("end_hold", cpu_hold, 0);
        chk("end_ready", load_ready, 0);
        chk("end_ovf", load_overflow, exp_ovf);
        foreach (g_words[w]) if (w < D) mmem[w] = g_words[w];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        address    = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_byte  = '0;
        tick();
        tick();
        chk("rst_ready", load_ready, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", load_done, 0);
        chk("rst_ovf", load_overflow, 0);
        reset = 1'b0;
        tick();

        // Fill whole array so every model entry is known.
        g_words.delete();
        for (int i = 0; i < D; i++) g_words.push_back(pat(i));
        run_load(32'(D), 1'b1);

        // Test-plan program: header 02 00 00 00, two words.
        g_words.delete();
        g_words.push_back(32'h00100513);
        g_words.push_back(32'h00200593);
        run_load(32'd2, 1'b0);

        tbl[0] = '{32'h0000_0000, 32'h00100513, 32'h00200593};
        tbl[1] = '{32'h0000_0002, 32'h00100513, 32'h00200593};
        tbl[2] = '{32'h0000_0001, 32'h00100513, 32'h00200593};
        tbl[3] = '{32'h0000_0004, 32'h00200593, pat(2)};
        tbl[4] = '{32'((D - 1) * 4), pat(D - 1), 32'h00100513};
        tbl[5] = '{32'((D - 1) * 4 + 2), pat(D - 1), 32'h00100513};
        tbl[6] = '{32'(D * 4 + 4), 32'h00200593, pat(2)};
        foreach (tbl[i]) begin
            address = tbl[i].addr;
            #1;
            chk($sformatf("tbl%0d_cur", i), current_word, tbl[i].cur);
            chk($sformatf("tbl%0d_next", i), next_word, tbl[i].nxt);
        end

        // Valid bytes outside a load are ignored.
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_byte  = 8'($urandom);
            tick();
        end
        load_valid = 1'b0;
        chk("idle_valid_done", load_done, 1);
        chk("idle_valid_ready", load_ready, 0);
        rd_check(8);

        // Zero-length load.
        g_words.delete();
        run_load(32'd0, 1'b1);
        rd_check(16);

        for (int r = 0; r < 3; r++) begin
            int unsigned n;
            n = $urandom_range(8, 1);
            g_words.delete();
            for (int i = 0; i < int'(n); i++) g_words.push_back($urandom);
            run_load(32'(n), 1'b1);
            rd_check(20);
        end

        // Overflow: D+1 words, last one discarded.
        g_words.delete();
        for (int i = 0; i <= D; i++) g_words.push_back($urandom);
        run_load(32'(D + 1), 1'b1);
        address = 32'((D - 1) * 4);
        #1;
        chk("wrap_cur", current_word, mmem[D-1]);
        chk("wrap_next", next_word, mmem[0]);
        rd_check(20);

        // Reset after 6 bytes of a 3-word load.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        begin
            logic [7:0] part[6];
            part = '{8'h03, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
            for (int i = 0; i < 6; i++) begin
                load_valid = 1'b1;
                load_byte  = part[i];
                tick();
            end
        end
        load_valid = 1'b0;
        chk("mid_hold", cpu_hold, 1);
        reset = 1'b1;
        #1;
        chk("rstmid_hold", cpu_hold, 0);
        chk("rstmid_ready", load_ready, 0);
        chk("rstmid_done", load_done, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_done", load_done, 0);
        rd_check(20);

        g_words.delete();
        for (int i = 0; i < 3; i++) g_words.push_back($urandom);
        run_load(32'd3, 1'b1);
        rd_check(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
